// File: rtl/ofdm_cp_remove.sv
`default_nettype none
// ============================================================================
// Module : ofdm_cp_remove
// Strips the cyclic prefix from an OFDM I/Q stream and hands each symbol to
// the FFT as one gap-free burst. Define OFDM_CP_REMOVE_SYMCNT_EN for sym_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module ofdm_cp_remove #(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int CP_LEN        = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic                     sym_start,
    input  logic [DATA_FFT_SIZE-1:0] data_in_i,
    input  logic [DATA_FFT_SIZE-1:0] data_in_q,
    input  logic                     flag_wayt_data,
    output logic                     valid,
    output logic [DATA_FFT_SIZE-1:0] data_out_i,
    output logic [DATA_FFT_SIZE-1:0] data_out_q,
    output logic                     last,
    output logic                     overflow,
    output logic                     frame_err
`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    ,
    output logic [15:0]              sym_cnt
`endif
);

    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam int PW   = SIZE_BUFFER + 2;
    localparam int AW   = SIZE_BUFFER + 1;
    localparam int DW   = 2 * DATA_FFT_SIZE;
    localparam logic [SIZE_BUFFER-1:0] CNT_LAST = SIZE_BUFFER'(NFFT - 1);
    localparam logic [SIZE_BUFFER-1:0] CP_LAST  = SIZE_BUFFER'(CP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    // A one-sample prefix is consumed entirely by the sym_start sample itself.
    localparam wr_state_t CP_ENTRY = (CP_LEN == 1) ? PASS : SKIP;

    logic [DW-1:0]          mem [0:2*NFFT-1];

    wr_state_t              wr_state;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          wr_commit;
    logic [SIZE_BUFFER-1:0] cp_cnt;
    logic [SIZE_BUFFER-1:0] u_cnt;

    rd_state_t              rd_state;
    logic [PW-1:0]          rd_ptr;
    logic [SIZE_BUFFER-1:0] rd_cnt;

    logic [1:0]             sym_count;

    logic                   full;
    logic                   wr_en;
    logic                   commit_now;
    logic                   burst_start;
    logic                   rd_en;

    assign full        = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en       = valid_in && (wr_state == PASS) && !sym_start && !full;
    assign commit_now  = wr_en && (u_cnt == CNT_LAST);
    assign burst_start = (rd_state == RD_IDLE) && (sym_count != 2'd0) && flag_wayt_data;
    assign rd_en       = (rd_state == RD_BURST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state  <= IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            cp_cnt    <= '0;
            u_cnt     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (valid_in) begin
                case (wr_state)
                    IDLE: begin
                        if (sym_start) begin
                            cp_cnt   <= SIZE_BUFFER'(1);
                            u_cnt    <= '0;
                            wr_state <= CP_ENTRY;
                        end
                    end
                    SKIP, PASS: begin
                        if (sym_start) begin
                            // Mid-symbol restart: drop the partial symbol, start a fresh prefix.
                            wr_ptr    <= wr_commit;
                            frame_err <= 1'b1;
                            cp_cnt    <= SIZE_BUFFER'(1);
                            u_cnt     <= '0;
                            wr_state  <= CP_ENTRY;
                        end else if (wr_state == SKIP) begin
                            cp_cnt <= cp_cnt + 1'b1;
                            if (cp_cnt == CP_LAST) begin
                                wr_state <= PASS;
                            end
                        end else if (full) begin
                            overflow <= 1'b1;
                            wr_ptr   <= wr_commit;
                            u_cnt    <= '0;
                            wr_state <= IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            u_cnt  <= u_cnt + 1'b1;
                            if (u_cnt == CNT_LAST) begin
                                wr_commit <= wr_ptr + 1'b1;
                                wr_state  <= IDLE;
                            end
                        end
                    end
                    default: wr_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {data_in_i, data_in_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_count <= 2'd0;
        end else if (commit_now && !burst_start) begin
            sym_count <= sym_count + 2'd1;
        end else if (!commit_now && burst_start) begin
            sym_count <= sym_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state <= RD_IDLE;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
        end else begin
            valid <= (rd_state == RD_BURST);
            last  <= (rd_state == RD_BURST) && (rd_cnt == CNT_LAST);
            case (rd_state)
                RD_IDLE: begin
                    if (burst_start) begin
                        rd_state <= RD_BURST;
                        rd_cnt   <= '0;
                    end
                end
                RD_BURST: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == CNT_LAST) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Registered RAM read; output holds its value between bursts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_i <= '0;
            data_out_q <= '0;
        end else if (rd_en) begin
            {data_out_i, data_out_q} <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef OFDM_CP_REMOVE_SYMCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt <= 16'd0;
        end else if (last) begin
            sym_cnt <= sym_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
